dev_timer_multi: RTL and testbench
==================================

Name: dev_timer_multi

Overview:
Memory-mapped multi-channel millisecond timer device on the processor's data bus. It is the parametrised successor of the single-channel timer, with NCH independent channels. Each channel adds writable LIMIT and COUNT registers, an enable bit, a one-shot mode and an interrupt enable. All interrupt-enabled ready flags are ORed onto a single IRQ line for the interrupt controller.

Parameters:
DBITS, 32, data and address bus width
NCH, 4, number of timer channels (1..16)
BASEADDR, 32'hF0000100, byte address of channel 0; channel i starts at BASEADDR + 16*i
MSTICKS, 100000, CLK cycles per timer tick (must be ≥ 1)

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RESET  input  1  synchronous, active-high reset, sampled on the rising edge of CLK
ABUS  input  DBITS  byte address from the CPU
WE  input  1  write strobe, valid in the same cycle as ABUS/DBUS_IN
DBUS_IN  input  DBITS  write data
DBUS_OUT  output  DBITS  read data, combinational from ABUS; 0 when not addressed or when WE=1
IRQ  output  1  registered-state OR over channels of (ready & ie)

Behaviour:
- Per-channel register map at offsets from the channel base:
  - +0 LIM: read/write.
  - +4 CNT: read/write.
  - +8 CTRL: {27'b0, oneshot[4], ie[3], en[2], overflow[1], ready[0]}.
  - +12: reserved (see Optional Feature).
  - Addresses outside BASEADDR .. BASEADDR+16*NCH-1, and misaligned addresses (ABUS[1:0] != 0), read 0 and ignore writes.
- Reset values, every channel: LIM=10, CNT=0, en=1, ready=0, overflow=0, ie=0, oneshot=0; prescaler=0; IRQ=0; DBUS_OUT=0 when unaddressed.
- Prescaler: one shared counter runs 0..MSTICKS-1. tick=1 in the cycle the counter equals MSTICKS-1, then the counter wraps to 0. With MSTICKS=1, tick=1 every cycle.
- On tick, for each channel with en=1:
  - If LIM != 0 and CNT == LIM-1: CNT<=0 and ready<=1.
    - If ready was already 1, overflow<=1 as well.
    - If oneshot=1, en<=0 as well.
  - Otherwise CNT<=CNT+1, with modulo 2^DBITS wrap. With LIM=0 the channel free-runs and never sets ready.
- Channels with en=0 hold CNT.
- Write to LIM: LIM<=DBUS_IN and CNT<=0 in the same edge.
- Write to CNT: CNT<=DBUS_IN.
- CPU writes win over same-cycle tick updates of CNT.
- CTRL write:
  - en, ie and oneshot load directly from DBUS_IN[4:2].
  - ready and overflow are write-0-to-clear: writing 0 clears the bit, writing 1 leaves it unchanged.
  - If a tick sets ready in the same cycle the CPU clears it, the set wins: ready=1 after the edge and overflow is unchanged.
- IRQ follows the flops with zero extra latency: it rises in the cycle after the edge that sets ready, when ie=1.
- Reads have zero latency: CTRL reflects the current flop state.
- RESET mid-count returns every channel and the prescaler to reset values on that edge. Bus writes in the reset cycle are ignored.

Optional Feature:
- Macro: DEVTIMER_PRESCALE_EN.
- Defined:
  - Each channel has its own prescaler and a PRE register at offset +12, read/write, reset value MSTICKS-1.
  - The channel ticks when its private counter equals PRE, then wraps to 0.
  - Writing PRE also clears that channel's prescaler counter.
- Undefined:
  - All channels share the single MSTICKS prescaler.
  - Offset +12 reads 0 and writes are ignored.

Test Plan:
- Reset, NCH=4, MSTICKS=4, no bus traffic -> ch0 ready sets on the edge after 40 cycles (10 ticks × 4); CNT reads 0..9 then 0; overflow sets at cycle 80.
- Write ch1 LIM=3, CTRL=0x18 (ie=1, oneshot=1, en=0), then CTRL=0x1C -> after 3 ticks ready=1, en=0, IRQ=1, CNT holds 0. Write CTRL=0x18 -> ready=0, IRQ=0.
- Write ch2 CNT=0xFFFFFFFF with LIM=0 -> next tick CNT=0, ready stays 0.
- CPU writes CTRL=0x04 on ch0 in the same cycle a tick reaches terminal count -> ready=1 after the edge (set wins).
- Read BASEADDR+16*NCH and BASEADDR+2 -> DBUS_OUT=0; writes there change no register.
- Assert RESET mid-count with a write of LIM=5 in the same cycle -> all registers at reset values, LIM=10; with DEVTIMER_PRESCALE_EN, PRE reads 3.

Source files
------------

// File: rtl/dev_timer_multi.sv
// Memory-mapped multi-channel millisecond timer with LIM/CNT/CTRL registers per channel and a shared IRQ.
// Optional per-channel prescaler with PRE register at +12 enabled by `define DEVTIMER_PRESCALE_EN.
module dev_timer_multi #(
  parameter int unsigned      DBITS    = 32,
  parameter int unsigned      NCH      = 4,
  parameter logic [DBITS-1:0] BASEADDR = 'hF0000100,
  parameter int unsigned      MSTICKS  = 100000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [DBITS-1:0] ABUS,
  input  logic             WE,
  input  logic [DBITS-1:0] DBUS_IN,
  output logic [DBITS-1:0] DBUS_OUT,
  output logic             IRQ
);

  typedef enum logic [1:0] {
    REG_LIM  = 2'd0,
    REG_CNT  = 2'd1,
    REG_CTRL = 2'd2,
    REG_PRE  = 2'd3
  } reg_e;

  localparam logic [DBITS-1:0] LP_END = BASEADDR + DBITS'(16 * NCH);

  logic [DBITS-1:0] r_lim [NCH];
  logic [DBITS-1:0] r_cnt [NCH];
  logic [NCH-1:0]   r_en, r_rdy, r_ovf, r_ie, r_os;
  logic [NCH-1:0]   w_tick, w_sel, w_term;
  logic [DBITS-1:0] w_off;
  logic             w_hit;
  logic [3:0]       w_ch;
  reg_e             w_reg;
  logic             w_unused;

  assign w_off    = ABUS - BASEADDR;
  assign w_hit    = (ABUS >= BASEADDR) && (ABUS < LP_END) && (ABUS[1:0] == 2'b00);
  assign w_ch     = w_off[7:4];
  assign w_reg    = reg_e'(w_off[3:2]);
  assign w_unused = ^{w_off[DBITS-1:8], w_off[1:0]};

  always_comb begin
    w_sel  = '0;
    w_term = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_sel[i]  = WE && w_hit && (w_ch == 4'(i));
      w_term[i] = r_en[i] && w_tick[i] && (r_lim[i] != '0) &&
                  (r_cnt[i] == r_lim[i] - DBITS'(1));
    end
  end

`ifdef DEVTIMER_PRESCALE_EN
  logic [DBITS-1:0] r_pre [NCH];
  logic [DBITS-1:0] r_pc  [NCH];

  always_comb begin
    w_tick = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_tick[i] = (r_pc[i] == r_pre[i]);
    end
  end

  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (RESET) begin
        r_pre[i] <= DBITS'(MSTICKS - 1);
        r_pc[i]  <= '0;
      end else if (w_sel[i] && (w_reg == REG_PRE)) begin
        r_pre[i] <= DBUS_IN;
        r_pc[i]  <= '0;
      end else if (w_tick[i]) begin
        r_pc[i]  <= '0;
      end else begin
        r_pc[i]  <= r_pc[i] + DBITS'(1);
      end
    end
  end
`else
  localparam int unsigned PW = (MSTICKS > 1) ? $clog2(MSTICKS) : 1;

  logic [PW-1:0] r_pc;
  logic          w_tick_all;

  assign w_tick_all = (r_pc == PW'(MSTICKS - 1));
  assign w_tick     = {NCH{w_tick_all}};

  always_ff @(posedge CLK) begin
    if (RESET || w_tick_all) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + PW'(1);
    end
  end
`endif

  // Tick update first, bus write afterwards so the CPU wins on CNT/LIM/en;
  // ready/overflow clears are suppressed when the tick hits terminal count.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (RESET) begin
        r_lim[i] <= DBITS'(10);
        r_cnt[i] <= '0;
        r_en[i]  <= 1'b1;
        r_rdy[i] <= 1'b0;
        r_ovf[i] <= 1'b0;
        r_ie[i]  <= 1'b0;
        r_os[i]  <= 1'b0;
      end else begin
        if (w_term[i]) begin
          r_cnt[i] <= '0;
          r_rdy[i] <= 1'b1;
          if (r_rdy[i]) r_ovf[i] <= 1'b1;
          if (r_os[i])  r_en[i]  <= 1'b0;
        end else if (r_en[i] && w_tick[i]) begin
          r_cnt[i] <= r_cnt[i] + DBITS'(1);
        end
        if (w_sel[i]) begin
          case (w_reg)
            REG_LIM: begin
              r_lim[i] <= DBUS_IN;
              r_cnt[i] <= '0;
            end
            REG_CNT: r_cnt[i] <= DBUS_IN;
            REG_CTRL: begin
              r_en[i] <= DBUS_IN[2];
              r_ie[i] <= DBUS_IN[3];
              r_os[i] <= DBUS_IN[4];
              if (!w_term[i]) begin
                if (!DBUS_IN[0]) r_rdy[i] <= 1'b0;
                if (!DBUS_IN[1]) r_ovf[i] <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    DBUS_OUT = '0;
    if (!WE && w_hit) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (w_ch == 4'(i)) begin
          case (w_reg)
            REG_LIM:  DBUS_OUT = r_lim[i];
            REG_CNT:  DBUS_OUT = r_cnt[i];
            REG_CTRL: DBUS_OUT = DBITS'({r_os[i], r_ie[i], r_en[i], r_ovf[i], r_rdy[i]});
`ifdef DEVTIMER_PRESCALE_EN
            REG_PRE:  DBUS_OUT = r_pre[i];
`else
            REG_PRE:  DBUS_OUT = '0;
`endif
            default:  DBUS_OUT = '0;
          endcase
        end
      end
    end
  end

  assign IRQ = |(r_rdy & r_ie);

endmodule

// File: tb/tb_dev_timer_multi.sv
// Scoreboard bench for dev_timer_multi (NCH=4, MSTICKS=4): directed bus accesses push expected
// values; a negedge monitor pops and compares against DBUS_OUT or IRQ.
module tb_dev_timer_multi;
  localparam int unsigned NCH  = 4;
  localparam int unsigned MST  = 4;
  localparam logic [31:0] BASE = 32'hF0000100;
`ifdef DEVTIMER_PRESCALE_EN
  localparam logic [31:0] PRE_EXP = 32'd3;
`else
  localparam logic [31:0] PRE_EXP = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [31:0] abus = '0;
  logic [31:0] din  = '0;
  logic [31:0] dout;
  logic        irq;

  always #5 clk = ~clk;

  dev_timer_multi #(
    .DBITS    (32),
    .NCH      (NCH),
    .BASEADDR (BASE),
    .MSTICKS  (MST)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .ABUS     (abus),
    .WE       (we),
    .DBUS_IN  (din),
    .DBUS_OUT (dout),
    .IRQ      (irq)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_irq;
  } exp_t;

  exp_t        q[$];
  bit          mon_v  = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int unsigned ncyc   = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (mon_v) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty actual=%h required=<entry>", dout);
      end else begin
        e   = q.pop_front();
        act = e.is_irq ? {31'b0, irq} : dout;
        checks++;
        if (act !== e.exp)
          begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", e.name, act, e.exp, ncyc);
          end
      end
    end
  end

  function automatic logic [31:0] A(input int unsigned ch, input int unsigned off);
    return BASE + 32'(16 * ch + off);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    mon_v = 1'b0;
    we    = 1'b0;
    ncyc++;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    abus  = a;
    we    = 1'b0;
    mon_v = 1'b1;
    q.push_back('{nm, e, 1'b0});
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    abus  = a;
    din   = d;
    we    = 1'b1;
    mon_v = 1'b1;
    q.push_back('{{nm, "_dout0"}, 32'h0, 1'b0});
    step();
  endtask

  task automatic chk_irq(input logic e, input string nm);
    abus  = '0;
    we    = 1'b0;
    mon_v = 1'b1;
    q.push_back('{nm, {31'b0, e}, 1'b1});
    step();
  endtask

  task automatic wait_until(input int unsigned n);
    while (ncyc < n) begin
      abus = '0;
      we   = 1'b0;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    ncyc = 0;

    // Reset values and free-running ch0 (LIM=10, 4 clocks per tick)
    rd(A(0, 8), 32'h04, "rst_ctrl0");
    rd(A(0, 0), 32'd10, "rst_lim0");
    rd(A(0, 4), 32'd0,  "rst_cnt0");
    chk_irq(1'b0, "rst_irq");
    rd(A(0, 4), 32'd1,  "cnt0_first_tick");
    wait_until(38);
    rd(A(0, 8), 32'h04, "ctrl0_before_term");
    rd(A(0, 4), 32'd9,  "cnt0_nine");
    rd(A(0, 8), 32'h05, "ctrl0_ready_at40");
    rd(A(0, 4), 32'd0,  "cnt0_wrapped");
    wait_until(79);
    rd(A(0, 8), 32'h05, "ctrl0_no_ovf_yet");
    rd(A(0, 8), 32'h07, "ctrl0_ovf_at80");
    chk_irq(1'b0, "irq_ie0");

    // Clear, then CTRL write coinciding with terminal tick: set wins
    wait_until(100);
    wr(A(0, 8), 32'h04, "wr_ctrl0_clr");
    rd(A(0, 8), 32'h04, "ctrl0_cleared");
    wait_until(119);
    wr(A(0, 8), 32'h04, "wr_ctrl0_race");
    rd(A(0, 8), 32'h05, "ctrl0_set_wins");
    wr(A(0, 8), 32'h04, "wr_ctrl0_clr2");
    rd(A(0, 8), 32'h04, "ctrl0_clear_no_tick");

    // ch1 one-shot with interrupt
    wr(A(1, 0), 32'd3,  "wr_lim1");
    wr(A(1, 8), 32'h18, "wr_ctrl1_off");
    rd(A(1, 8), 32'h18, "ctrl1_off");
    wr(A(1, 8), 32'h1C, "wr_ctrl1_on");
    wait_until(135);
    rd(A(1, 8), 32'h1C, "ctrl1_before_term");
    rd(A(1, 8), 32'h19, "ctrl1_oneshot_done");
    chk_irq(1'b1, "irq_ch1");
    rd(A(1, 4), 32'd0,  "cnt1_zero");
    wait_until(140);
    rd(A(1, 4), 32'd0,  "cnt1_held");
    wr(A(1, 8), 32'h18, "wr_ctrl1_ack");
    rd(A(1, 8), 32'h18, "ctrl1_acked");
    chk_irq(1'b0, "irq_cleared");

    // ch2 free-run wrap with LIM=0
    wr(A(2, 0), 32'd0,        "wr_lim2_zero");
    wr(A(2, 4), 32'hFFFFFFFF, "wr_cnt2_max");
    wr(A(2, 8), 32'h04,       "wr_ctrl2_clr");
    rd(A(2, 4), 32'hFFFFFFFF, "cnt2_max");
    rd(A(2, 4), 32'd0,        "cnt2_wrap");
    rd(A(2, 8), 32'h04,       "ctrl2_no_ready");

    // Decode boundaries
    rd(A(NCH, 0), 32'd0,   "rd_past_end");
    rd(BASE + 32'd2, 32'd0, "rd_misaligned");
    rd(A(0, 12), PRE_EXP,  "rd_offset12");
    wr(A(NCH, 0), 32'd5,    "wr_past_end");
    wr(BASE + 32'd2, 32'd5, "wr_misaligned");
    wr(BASE - 32'd4, 32'd5, "wr_below_base");
    rd(A(0, 0), 32'd10,    "lim0_untouched");
    rd(A(3, 0), 32'd10,    "lim3_untouched");
    rd(BASE - 32'd4, 32'd0, "rd_below_base");

    // Reset mid-count (prescaler at 1) with a simultaneous LIM write
    wait_until(161);
    rst   = 1'b1;
    we    = 1'b1;
    abus  = A(0, 0);
    din   = 32'd5;
    mon_v = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    we   = 1'b0;
    ncyc = 0;
    rd(A(0, 0), 32'd10, "post_rst_lim0");
    rd(A(0, 4), 32'd0,  "post_rst_cnt0");
    rd(A(0, 8), 32'h04, "post_rst_ctrl0");
    rd(A(0, 4), 32'd0,  "post_rst_cnt0_pre");
    rd(A(0, 4), 32'd1,  "post_rst_cnt0_tick");
    rd(A(1, 8), 32'h04, "post_rst_ctrl1");
    rd(A(1, 0), 32'd10, "post_rst_lim1");
    chk_irq(1'b0, "post_rst_irq");
    rd(A(0, 12), PRE_EXP, "post_rst_pre0");
    rd(A(2, 0), 32'd10, "post_rst_lim2");

    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
